// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like port between IF and load/store, data-first with request lock and in-order return steering
module mem_port_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic             lock_v, lock_id, sel, full, acc, ret, head, sel_req;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    wptr, rptr;
    logic [DEPTH-1:0] fifo;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        full         = cnt == CW'(DEPTH);
        sel          = lock_v ? lock_id : data_req;
        sel_req      = sel ? data_req : inst_req;
        mem_req      = ~full & sel_req;
        mem_wr       = sel ? data_wr    : inst_wr;
        mem_size     = sel ? data_size  : inst_size;
        mem_wstrb    = sel ? data_wstrb : inst_wstrb;
        mem_addr     = sel ? data_addr  : inst_addr;
        mem_wdata    = sel ? data_wdata : inst_wdata;
        acc          = mem_req & mem_addr_ok;
        data_addr_ok = acc & sel;
        inst_addr_ok = acc & ~sel;
        head         = fifo[rptr];
        ret          = mem_data_ok & (cnt != '0);
        data_data_ok = ret & head;
        inst_data_ok = ret & ~head;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
        busy         = cnt != '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_v  <= 1'b0;
            lock_id <= 1'b0;
            cnt     <= '0;
            wptr    <= '0;
            rptr    <= '0;
            fifo    <= '0;
        end else begin
            if (acc) begin
                fifo[wptr] <= sel;
                wptr       <= inc(wptr);
            end
            if (ret)
                rptr <= inc(rptr);
            if (acc & ~ret)
                cnt <= cnt + CW'(1);
            else if (ret & ~acc)
                cnt <= cnt - CW'(1);
            // a dropped locked request releases the lock so the other side cannot starve
            if (acc | (lock_v & ~sel_req))
                lock_v <= 1'b0;
            else if (mem_req & ~lock_v) begin
                lock_v  <= 1'b1;
                lock_id <= sel;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios for priority, locking, return steering, full FIFO, spurious returns and reset
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        busy;
    int          tests = 0;
    int          fails = 0;

    localparam logic [31:0] IA = 32'h1C00_0000;
    localparam logic [31:0] DA = 32'h1C00_0100;

    mem_port_arbiter #(.DEPTH(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0; inst_addr = IA; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0; data_addr = DA; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic test_reset();
        resetn = 0;
        idle();
        mem_data_ok = 1;
        tick();
        tick();
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin
            fails++; $display("FAIL reset_oks got %b exp 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
        tests++; if (dut.cnt !== 2'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", dut.cnt); end
        mem_data_ok = 0;
        resetn = 1;
        tick();
    endtask

    task automatic test_priority();
        idle();
        inst_req = 1;
        data_req = 1; data_wr = 1; data_wdata = 32'hDEAD_0001; data_wstrb = 4'hF;
        mem_addr_ok = 1;
        #1;
        tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL prio_mem_req got %b exp 1", mem_req); end
        tests++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin fails++; $display("FAIL prio_addr_ok got %b exp 10", {data_addr_ok, inst_addr_ok}); end
        tests++; if (mem_addr !== DA) begin fails++; $display("FAIL prio_mem_addr got %h exp %h", mem_addr, DA); end
        tests++; if ({mem_wr, mem_wstrb, mem_wdata} !== {1'b1, 4'hF, 32'hDEAD_0001}) begin
            fails++; $display("FAIL prio_fields got %b %h %h exp 1 f dead0001", mem_wr, mem_wstrb, mem_wdata); end
        tick();
        data_req = 0;
        #1;
        tests++; if ({data_addr_ok, inst_addr_ok} !== 2'b01) begin fails++; $display("FAIL prio_if_accept got %b exp 01", {data_addr_ok, inst_addr_ok}); end
        tests++; if ({mem_addr, mem_wr} !== {IA, 1'b0}) begin fails++; $display("FAIL prio_if_addr got %h %b exp %h 0", mem_addr, mem_wr, IA); end
        tick();
        inst_req = 0; mem_addr_ok = 0;
        #1;
        tests++; if ({dut.cnt, busy} !== {2'd2, 1'b1}) begin fails++; $display("FAIL prio_cnt got %0d %b exp 2 1", dut.cnt, busy); end
        mem_data_ok = 1; mem_rdata = 32'h1111_0000;
        #1;
        tests++; if ({data_data_ok, inst_data_ok, data_rdata} !== {2'b10, 32'h1111_0000}) begin
            fails++; $display("FAIL prio_ret0 got %b%b %h exp 10 11110000", data_data_ok, inst_data_ok, data_rdata); end
        tick();
        mem_rdata = 32'h2222_0000;
        #1;
        tests++; if ({data_data_ok, inst_data_ok, inst_rdata} !== {2'b01, 32'h2222_0000}) begin
            fails++; $display("FAIL prio_ret1 got %b%b %h exp 01 22220000", data_data_ok, inst_data_ok, inst_rdata); end
        tick();
        mem_data_ok = 0;
        #1;
        tests++; if ({dut.cnt, busy} !== 3'b000) begin fails++; $display("FAIL prio_drain got %0d %b exp 0 0", dut.cnt, busy); end
    endtask

    task automatic test_lock();
        idle();
        inst_req = 1;
        #1;
        tests++; if ({mem_req, inst_addr_ok, mem_addr} !== {2'b10, IA}) begin
            fails++; $display("FAIL lock_c0 got %b%b %h exp 10 %h", mem_req, inst_addr_ok, mem_addr, IA); end
        tick();
        data_req = 1;
        #1;
        tests++; if ({mem_addr, data_addr_ok} !== {IA, 1'b0}) begin fails++; $display("FAIL lock_c1 got %h %b exp %h 0", mem_addr, data_addr_ok, IA); end
        tests++; if (dut.lock_v !== 1'b1) begin fails++; $display("FAIL lock_v_set got %b exp 1", dut.lock_v); end
        tick();
        #1;
        tests++; if (mem_addr !== IA) begin fails++; $display("FAIL lock_c2 got %h exp %h", mem_addr, IA); end
        tick();
        mem_addr_ok = 1;
        #1;
        tests++; if ({inst_addr_ok, data_addr_ok, mem_addr} !== {2'b10, IA}) begin
            fails++; $display("FAIL lock_c3 got %b%b %h exp 10 %h", inst_addr_ok, data_addr_ok, mem_addr, IA); end
        tick();
        inst_req = 0;
        #1;
        tests++; if ({inst_addr_ok, data_addr_ok, mem_addr} !== {2'b01, DA}) begin
            fails++; $display("FAIL lock_c4 got %b%b %h exp 01 %h", inst_addr_ok, data_addr_ok, mem_addr, DA); end
        tick();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #1;
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin fails++; $display("FAIL lock_ret0 got %b exp 10", {inst_data_ok, data_data_ok}); end
        tick();
        #1;
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin fails++; $display("FAIL lock_ret1 got %b exp 01", {inst_data_ok, data_data_ok}); end
        tick();
        mem_data_ok = 0;
    endtask

    task automatic test_back_to_back();
        idle();
        inst_req = 1; mem_addr_ok = 1;
        #1;
        tests++; if (inst_addr_ok !== 1'b1) begin fails++; $display("FAIL b2b_if_acc got %b exp 1", inst_addr_ok); end
        tick();
        inst_req = 0; data_req = 1;
        #1;
        tests++; if (data_addr_ok !== 1'b1) begin fails++; $display("FAIL b2b_d_acc got %b exp 1", data_addr_ok); end
        tick();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hAAAA_0001;
        #1;
        tests++; if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'hAAAA_0001}) begin
            fails++; $display("FAIL b2b_ret0 got %b%b %h exp 10 aaaa0001", inst_data_ok, data_data_ok, inst_rdata); end
        tick();
        mem_rdata = 32'hBBBB_0002;
        #1;
        tests++; if ({inst_data_ok, data_data_ok, data_rdata} !== {2'b01, 32'hBBBB_0002}) begin
            fails++; $display("FAIL b2b_ret1 got %b%b %h exp 01 bbbb0002", inst_data_ok, data_data_ok, data_rdata); end
        tick();
        mem_data_ok = 0;
        #1;
        tests++; if ({dut.cnt, busy} !== 3'b000) begin fails++; $display("FAIL b2b_drain got %0d %b exp 0 0", dut.cnt, busy); end
    endtask

    task automatic test_full();
        idle();
        inst_req = 1; mem_addr_ok = 1;
        tick();
        inst_req = 0; data_req = 1;
        tick();
        data_req = 0; inst_req = 1;
        #1;
        tests++; if ({mem_req, inst_addr_ok, busy} !== 3'b001) begin
            fails++; $display("FAIL full_block got %b%b%b exp 001", mem_req, inst_addr_ok, busy); end
        tick();
        tests++; if (dut.cnt !== 2'd2) begin fails++; $display("FAIL full_hold got %0d exp 2", dut.cnt); end
        mem_data_ok = 1;
        #1;
        tests++; if ({inst_data_ok, mem_req} !== 2'b10) begin fails++; $display("FAIL full_pop got %b%b exp 10", inst_data_ok, mem_req); end
        tick();
        tests++; if (dut.cnt !== 2'd1) begin fails++; $display("FAIL full_after_pop got %0d exp 1", dut.cnt); end
        tests++; if ({data_data_ok, inst_addr_ok} !== 2'b11) begin fails++; $display("FAIL full_pushpop got %b exp 11", {data_data_ok, inst_addr_ok}); end
        tick();
        tests++; if (dut.cnt !== 2'd1) begin fails++; $display("FAIL full_pushpop_cnt got %0d exp 1", dut.cnt); end
        inst_req = 0; data_req = 1; mem_data_ok = 0;
        #1;
        tests++; if (data_addr_ok !== 1'b1) begin fails++; $display("FAIL full_refill got %b exp 1", data_addr_ok); end
        tick();
        data_req = 0; mem_addr_ok = 0;
        tests++; if (dut.cnt !== 2'd2) begin fails++; $display("FAIL full_refill_cnt got %0d exp 2", dut.cnt); end
        mem_data_ok = 1;
        #1;
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin fails++; $display("FAIL full_order0 got %b exp 10", {inst_data_ok, data_data_ok}); end
        tick();
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin fails++; $display("FAIL full_order1 got %b exp 01", {inst_data_ok, data_data_ok}); end
        tick();
        mem_data_ok = 0;
        tests++; if (dut.cnt !== 2'd0) begin fails++; $display("FAIL full_drain got %0d exp 0", dut.cnt); end
    endtask

    task automatic test_spurious();
        idle();
        mem_data_ok = 1;
        #1;
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin fails++; $display("FAIL spur_ok got %b exp 00", {inst_data_ok, data_data_ok}); end
        tick();
        mem_data_ok = 0;
        tests++; if ({dut.cnt, busy} !== 3'b000) begin fails++; $display("FAIL spur_cnt got %0d %b exp 0 0", dut.cnt, busy); end
    endtask

    task automatic test_reset_mid();
        idle();
        inst_req = 1; mem_addr_ok = 1;
        tick();
        inst_req = 0; data_req = 1; mem_addr_ok = 0;
        tests++; if (dut.cnt !== 2'd1) begin fails++; $display("FAIL rmid_cnt1 got %0d exp 1", dut.cnt); end
        tick();
        tests++; if ({dut.lock_v, dut.lock_id} !== 2'b11) begin fails++; $display("FAIL rmid_lock got %b exp 11", {dut.lock_v, dut.lock_id}); end
        resetn = 0; data_req = 0;
        tick();
        tests++; if ({dut.cnt, dut.lock_v, busy} !== 4'b0000) begin
            fails++; $display("FAIL rmid_cleared got %0d %b %b exp 0 0 0", dut.cnt, dut.lock_v, busy); end
        resetn = 1; mem_data_ok = 1;
        #1;
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin fails++; $display("FAIL rmid_late got %b exp 00", {inst_data_ok, data_data_ok}); end
        tick();
        mem_data_ok = 0;
        tests++; if (dut.cnt !== 2'd0) begin fails++; $display("FAIL rmid_late_cnt got %0d exp 0", dut.cnt); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_lock();
        test_back_to_back();
        test_full();
        test_spurious();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
